imsic_msi_tx: RTL

- MSI initiator that delivers interrupt identities to the IMSIC slave at IMSICBase (0x2400_0000) over a single-beat AXI4 write path.
- Sits between MSI-mode interrupt sources (APLIC-style forwarder, devices) and the crossbar, as an additional master port.
- Queues requests, issues seteipnum_le writes to the selected interrupt file page, and tracks B responses with bounded retry.

---
 rtl/imsic_msi_tx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/imsic_msi_tx.sv
// MSI initiator: queues (file, eiid) requests and delivers each as a single-beat
// seteipnum_le write into the IMSIC window, retrying a bounded number of times on
// error responses before dropping the request.
module imsic_msi_tx #(
  parameter int unsigned NrIntpFiles = 3,
  parameter int unsigned EiidWidth   = 11,
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned IdWidth     = 4,
  parameter logic [63:0] ImsicBase   = 64'h2400_0000,
  parameter logic [63:0] FileStride  = 64'h1000,
  parameter int unsigned FifoDepth   = 4,
  parameter int unsigned MaxRetries  = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [$clog2(NrIntpFiles)-1:0] req_file_i,
  input  logic [EiidWidth-1:0]           req_eiid_i,
  output logic                           aw_valid_o,
  input  logic                           aw_ready_i,
  output logic [AddrWidth-1:0]           aw_addr_o,
  output logic [IdWidth-1:0]             aw_id_o,
  output logic                           w_valid_o,
  input  logic                           w_ready_i,
  output logic [DataWidth-1:0]           w_data_o,
  output logic [DataWidth/8-1:0]         w_strb_o,
  output logic                           w_last_o,
  input  logic                           b_valid_i,
  output logic                           b_ready_o,
  input  logic [1:0]                     b_resp_i,
  output logic                           invalid_o,
  output logic                           err_o,
  output logic                           busy_o
);

  localparam int unsigned FileW  = $clog2(NrIntpFiles);
  localparam int unsigned PtrW   = $clog2(FifoDepth);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned RetryW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
  localparam int unsigned StrbW  = DataWidth / 8;

  typedef enum logic [1:0] {Idle = 2'd0, Send = 2'd1, WaitB = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [FileW-1:0]    file_mem [FifoDepth];
  logic [EiidWidth-1:0] eiid_mem [FifoDepth];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     cnt_q;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                invalid_q, err_q, err_d;
  logic                fifo_full, fifo_empty, req_bad, req_hs, push, pop;
  logic                aw_valid_c, w_valid_c, b_ready_c;
  logic                aw_hs, w_hs, b_hs, b_ok;
  logic [FileW-1:0]    head_file;
  logic [EiidWidth-1:0] head_eiid;
  logic [AddrWidth-1:0] head_addr;

  assign fifo_full  = (cnt_q == CntW'(FifoDepth));
  assign fifo_empty = (cnt_q == '0);
  assign req_bad    = (req_eiid_i == '0) || (32'(req_file_i) >= NrIntpFiles);
  assign req_hs     = req_valid_i && req_ready_o;
  assign push       = req_hs && !req_bad;
  assign head_file  = file_mem[rd_ptr_q];
  assign head_eiid  = eiid_mem[rd_ptr_q];
  assign head_addr  = AddrWidth'(ImsicBase) + AddrWidth'(head_file) * AddrWidth'(FileStride);
  assign aw_hs      = aw_valid_c && aw_ready_i;
  assign w_hs       = w_valid_c && w_ready_i;
  assign b_hs       = b_ready_c && b_valid_i;
  assign b_ok       = (b_resp_i == 2'b00) || (b_resp_i == 2'b01);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= Idle;
    else         state_q <= state_d;
  end

  // Next-state: issue head, wait for both handshakes, then resolve the B response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      Idle:    if (!fifo_empty) state_d = Send;
      Send:    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WaitB;
      WaitB:   if (b_hs) state_d = (b_ok || retry_q == RetryW'(MaxRetries)) ? Idle : Send;
      default: state_d = Idle;
    endcase
  end

  // Outputs and datapath controls derived from the current state.
  always_comb begin
    aw_valid_c = 1'b0;
    w_valid_c  = 1'b0;
    b_ready_c  = 1'b0;
    pop        = 1'b0;
    err_d      = 1'b0;
    retry_d    = retry_q;
    case (state_q)
      Send: begin
        aw_valid_c = !aw_done_q;
        w_valid_c  = !w_done_q;
      end
      WaitB: begin
        b_ready_c = 1'b1;
        if (b_hs) begin
          if (b_ok) begin
            pop     = 1'b1;
            retry_d = '0;
          end else if (retry_q == RetryW'(MaxRetries)) begin
            pop     = 1'b1;
            err_d   = 1'b1;
            retry_d = '0;
          end else begin
            retry_d = retry_q + RetryW'(1);
          end
        end
      end
      default: ;
    endcase
    // Done flags only live while SEND persists; leaving SEND re-arms both channels.
    aw_done_d = (state_q == Send && state_d == Send) ? (aw_done_q || aw_hs) : 1'b0;
    w_done_d  = (state_q == Send && state_d == Send) ? (w_done_q || w_hs) : 1'b0;
  end

  // Queue pointers, occupancy, retry counter and pulse registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      retry_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      invalid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q     <= cnt_q + CntW'(push) - CntW'(pop);
      retry_q   <= retry_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      invalid_q <= req_hs && req_bad;
      err_q     <= err_d;
    end
  end

  // Queue storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk_i) begin
    if (push) begin
      file_mem[wr_ptr_q] <= req_file_i;
      eiid_mem[wr_ptr_q] <= req_eiid_i;
    end
  end

  // Every output is forced low while reset is held.
  assign req_ready_o = rst_ni && !fifo_full;
  assign aw_valid_o  = rst_ni && aw_valid_c;
  assign w_valid_o   = rst_ni && w_valid_c;
  assign b_ready_o   = rst_ni && b_ready_c;
  assign aw_addr_o   = {AddrWidth{rst_ni}} & head_addr;
  assign aw_id_o     = '0;
  assign w_data_o    = {DataWidth{rst_ni}} & DataWidth'(head_eiid);
  assign w_strb_o    = {StrbW{rst_ni}} & StrbW'(8'h0F);
  assign w_last_o    = rst_ni;
  assign invalid_o   = rst_ni && invalid_q;
  assign err_o       = rst_ni && err_q;
  assign busy_o      = rst_ni && (!fifo_empty || state_q != Idle);

endmodule
